// File: rtl/rx_frame_assembler_pkg.sv
// Shared constants and the completed-frame entry type for the receive frame assembler.
package rx_frame_assembler_pkg;

    // Must match the decoder's frame input width.
    localparam int unsigned FrameLen  = 16;
    // Completed-frame FIFO entries; power of 2.
    localparam int unsigned FifoDepth = 2;

    typedef struct packed {
        logic [FrameLen-1:0] data;
        logic                last;
    } frame_entry_t;

endpackage

// File: rtl/rx_frame_assembler_frame_fifo.sv
// Small synchronous FIFO of completed frames with synchronous clear.
module rx_frame_assembler_frame_fifo
    import rx_frame_assembler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FifoDepth
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         push_i,
    input  frame_entry_t wdata_i,
    input  logic         pop_i,
    output frame_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    frame_entry_t        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Status flags, guarded push/pop and next-state pointers/count.
    always_comb begin
        full_o   = (count_q == CntW'(FIFO_DEPTH));
        empty_o  = (count_q == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-2 depth: pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) count_d = count_q + CntW'(1);
            if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are masked by empty_o so no reset is needed.
    always_ff @(posedge sys_clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// Collects the serial coded-bit stream into MSB-first frames and queues them for the decoder.
module rx_frame_assembler
    import rx_frame_assembler_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = FrameLen,
    parameter int unsigned FIFO_DEPTH = FifoDepth
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_rx_bit,
    input  logic                 i_rx_valid,
    input  logic                 i_rx_last,
    output logic                 o_rx_ready,
    output logic [FRAME_LEN-1:0] o_frame,
    output logic                 o_frame_last,
    output logic                 o_frame_valid,
    input  logic                 i_frame_ready,
    output logic [15:0]          o_frame_cnt
);

    localparam int unsigned BitCntW = $clog2(FRAME_LEN);

    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [FRAME_LEN-1:0] word;
    logic [BitCntW-1:0]   bit_pos;
    logic                 at_last_pos;
    logic                 accept;
    logic                 complete;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    frame_entry_t         push_entry;
    frame_entry_t         head;

    // Intake handshake, frame assembly and next-state for counters/shift register.
    always_comb begin
        at_last_pos = (bit_cnt_q == BitCntW'(FRAME_LEN - 1));
        // Ready never looks at i_frame_ready, so a full FIFO refuses a completing bit even
        // when a pop happens on the same edge.
        o_rx_ready  = !fifo_full || (!at_last_pos && !i_rx_last);
        accept      = i_rx_valid && o_rx_ready;
        complete    = accept && (at_last_pos || i_rx_last);
        bit_pos     = BitCntW'(FRAME_LEN - 1) - bit_cnt_q;
        word        = shift_q;
        word[bit_pos] = i_rx_bit;
        // Low-order positions not yet written are still zero: tail padding comes for free.
        push_entry.data = word;
        push_entry.last = i_rx_last;
        pop         = !fifo_empty && i_frame_ready && !i_flush;

        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
        if (i_flush) begin
            bit_cnt_d   = '0;
            shift_d     = '0;
            frame_cnt_d = '0;
        end else begin
            if (complete) begin
                bit_cnt_d = '0;
                shift_d   = '0;
            end else if (accept) begin
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                shift_d   = word;
            end
            if (pop) frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Partial-frame and pop-counter state.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    rx_frame_assembler_frame_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_frame_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear_i (i_flush),
        .push_i  (complete && !i_flush),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head-of-FIFO view; the FIFO returns zero when empty.
    always_comb begin
        o_frame_valid = !fifo_empty;
        o_frame       = head.data;
        o_frame_last  = head.last;
        o_frame_cnt   = frame_cnt_q;
    end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Randomised and directed bench for rx_frame_assembler against a queue-based reference model.
module tb_rx_frame_assembler;

    localparam int Depth = 2;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        i_rx_bit;
    logic        i_rx_valid;
    logic        i_rx_last;
    logic        o_rx_ready;
    logic [15:0] o_frame;
    logic        o_frame_last;
    logic        o_frame_valid;
    logic        i_frame_ready;
    logic [15:0] o_frame_cnt;

    rx_frame_assembler dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .i_flush      (i_flush),
        .i_rx_bit     (i_rx_bit),
        .i_rx_valid   (i_rx_valid),
        .i_rx_last    (i_rx_last),
        .o_rx_ready   (o_rx_ready),
        .o_frame      (o_frame),
        .o_frame_last (o_frame_last),
        .o_frame_valid(o_frame_valid),
        .i_frame_ready(i_frame_ready),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: completed frames, bits of the frame in progress, pop count.
    logic [15:0] mq_data[$];
    bit          mq_last[$];
    bit          mbits[$];
    logic [15:0] mcnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic bit model_ready(input bit last);
        return (mq_data.size() != Depth) || (mbits.size() < 15 && !last);
    endfunction

    task automatic model_clear();
        mq_data.delete();
        mq_last.delete();
        mbits.delete();
        mcnt = '0;
    endtask

    // Compare every output against the model for the currently driven inputs.
    task automatic compare_all();
        logic [15:0] exp_frame;
        bit          exp_last;
        exp_frame = (mq_data.size() != 0) ? mq_data[0] : 16'h0;
        exp_last  = (mq_last.size() != 0) ? mq_last[0] : 1'b0;
        chk("frame_valid", {31'h0, o_frame_valid}, {31'h0, mq_data.size() != 0});
        chk("frame", {16'h0, o_frame}, {16'h0, exp_frame});
        chk("frame_last", {31'h0, o_frame_last}, {31'h0, exp_last});
        chk("frame_cnt", {16'h0, o_frame_cnt}, {16'h0, mcnt});
        chk("rx_ready", {31'h0, o_rx_ready}, {31'h0, model_ready(i_rx_last)});
    endtask

    // One clock: drive, compare, advance the model at the edge. Entered just after a negedge.
    task automatic step(input bit v, input bit b, input bit last, input bit fr, input bit fl);
        bit          acc;
        bit          pp;
        logic [15:0] w;
        i_rx_valid    = v;
        i_rx_bit      = b;
        i_rx_last     = last;
        i_frame_ready = fr;
        i_flush       = fl;
        #1;
        compare_all();
        acc = v && model_ready(last);
        pp  = fr && (mq_data.size() != 0);
        @(posedge sys_clk);
        if (fl) begin
            model_clear();
        end else begin
            if (pp) begin
                void'(mq_data.pop_front());
                void'(mq_last.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (acc) begin
                mbits.push_back(b);
                if (mbits.size() == 16 || last) begin
                    w = '0;
                    for (int i = 0; i < mbits.size(); i++) w[15-i] = mbits[i];
                    mq_data.push_back(w);
                    mq_last.push_back(last);
                    mbits.delete();
                end
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic send_word(input logic [15:0] w, input bit fr);
        for (int i = 15; i >= 0; i--) step(1'b1, w[i], 1'b0, fr, 1'b0);
    endtask

    logic [15:0] pat;

    initial begin
        rst = 1'b0; i_flush = 0; i_rx_bit = 0; i_rx_valid = 0; i_rx_last = 0; i_frame_ready = 0;
        model_clear();
        repeat (2) @(negedge sys_clk);
        chk("rst_valid", {31'h0, o_frame_valid}, 32'h0);
        chk("rst_ready", {31'h0, o_rx_ready}, 32'h1);
        chk("rst_frame", {16'h0, o_frame}, 32'h0);
        rst = 1'b1;
        @(negedge sys_clk);

        // 0xB1E5 MSB first, consumer stalled.
        pat = 16'hB1E5;
        send_word(pat, 1'b0);
        chk("lit_b1e5", {16'h0, o_frame}, 32'hB1E5);
        chk("lit_b1e5_valid", {31'h0, o_frame_valid}, 32'h1);
        chk("lit_b1e5_last", {31'h0, o_frame_last}, 32'h0);
        step(0, 0, 0, 1, 0);
        chk("lit_pop_cnt", {16'h0, o_frame_cnt}, 32'h1);
        chk("lit_pop_valid", {31'h0, o_frame_valid}, 32'h0);

        // Short message 1,1,0,1,1 with last.
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("lit_d800", {16'h0, o_frame}, 32'hD800);
        chk("lit_d800_last", {31'h0, o_frame_last}, 32'h1);
        step(0, 0, 0, 1, 0);

        // Backpressure: 48 valid bits with consumer stalled; the 48th is refused.
        for (int i = 0; i < 48; i++) step(1, 1'($urandom), 0, 0, 0);
        chk("lit_full_ready", {31'h0, o_rx_ready}, 32'h0);
        step(0, 0, 0, 1, 0);
        chk("lit_after_pop_ready", {31'h0, o_rx_ready}, 32'h1);
        step(1, 1'($urandom), 0, 0, 0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        chk("lit_drain_cnt", {16'h0, o_frame_cnt}, 32'h5);

        // One entry queued; completing bit and pop share an edge.
        send_word(16'h1234, 1'b0);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("lit_swap_cnt", {16'h0, o_frame_cnt}, 32'h6);
        chk("lit_swap_head", {16'h0, o_frame}, 32'hFFFE);
        step(0, 0, 0, 1, 0);

        // Flush with simultaneous accept and pop.
        send_word(16'h0F0F, 1'b0);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 1);
        chk("lit_flush_valid", {31'h0, o_frame_valid}, 32'h0);
        chk("lit_flush_cnt", {16'h0, o_frame_cnt}, 32'h0);
        send_word(16'hA5C3, 1'b0);
        chk("lit_clean_frame", {16'h0, o_frame}, 32'hA5C3);
        step(0, 0, 0, 1, 0);

        // Asynchronous reset between edges, mid-frame, with a frame queued.
        send_word(16'h5555, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("lit_arst_valid", {31'h0, o_frame_valid}, 32'h0);
        chk("lit_arst_frame", {16'h0, o_frame}, 32'h0);
        chk("lit_arst_cnt", {16'h0, o_frame_cnt}, 32'h0);
        chk("lit_arst_ready", {31'h0, o_rx_ready}, 32'h1);
        model_clear();
        i_rx_valid = 0;
        @(negedge sys_clk);
        #2 rst = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
